// File: rtl/scc_pkg.sv
// Shared types and constants for the SCC wave RAM arbiter.
// Channel ids, RAM geometry and the per-port hold-register layout.
package scc_pkg;

    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_B = 3'd1;
    localparam logic [2:0] CH_C = 3'd2;
    localparam logic [2:0] CH_D = 3'd3;
    localparam logic [2:0] CH_E = 3'd4;

    localparam int WAVE_DEPTH = 32;
    localparam int RAM_DEPTH  = 160;

    localparam logic [1:0] CPU_MAX_WAIT      = 2'd2;
    localparam logic [7:0] INVALID_READ_DATA = 8'hFF;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    typedef struct packed {
        logic [2:0] id;
        logic [4:0] a;
        logic [7:0] d;
        op_e        op;
    } hold_t;

    // Channel ids past the last wave bank have no RAM behind them.
    function automatic logic id_valid(input logic [2:0] id);
        return int'(id) < (RAM_DEPTH / WAVE_DEPTH);
    endfunction

endpackage

// File: rtl/scc_wave_req_slot.sv
// One-entry request holding register for a wave RAM port.
// Tracks pend and flags a capture that overwrites an unserved entry.
module scc_wave_req_slot
    import scc_pkg::*;
(
    input  logic  clk,
    input  logic  nreset,
    input  logic  cap,
    input  hold_t cap_entry,
    input  logic  grant,
    output logic  pend,
    output hold_t entry,
    output logic  ovr_hit
);

    logic  pend_q;
    logic  pend_d;
    hold_t entry_q;
    hold_t entry_d;

    // Grant consumes the old entry first, so a same-cycle capture survives.
    always_comb begin
        pend_d  = pend_q;
        entry_d = entry_q;
        ovr_hit = cap & pend_q & ~grant;
        if (grant) begin
            pend_d = 1'b0;
        end
        if (cap) begin
            pend_d  = 1'b1;
            entry_d = cap_entry;
        end
    end

    // Hold register state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pend_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            pend_q  <= pend_d;
            entry_q <= entry_d;
        end
    end

    assign pend  = pend_q;
    assign entry = entry_q;

endmodule

// File: rtl/scc_wave_ram_arbiter.sv
// Arbiter for the shared SCC/SCC-I wave RAM: CPU port vs tone fetch port.
// Tone has priority; the CPU is forced through after two lost cycles.
module scc_wave_ram_arbiter
    import scc_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       scci_enable,
    input  logic       cpu_ce,
    input  logic [2:0] cpu_id,
    input  logic [4:0] cpu_a,
    input  logic [7:0] cpu_d,
    input  logic       cpu_oe,
    input  logic       cpu_we,
    output logic [7:0] cpu_q,
    output logic       cpu_q_en,
    input  logic       tone_req,
    input  logic [2:0] tone_id,
    input  logic [4:0] tone_a,
    output logic [7:0] tone_q,
    output logic       tone_q_en,
    output logic [7:0] ram_a,
    output logic [7:0] ram_d,
    output logic       ram_we,
    output logic       ram_re,
    input  logic [7:0] ram_q,
    output logic       overrun
);

    logic  cpu_cap;
    hold_t cpu_cap_e;
    hold_t tone_cap_e;
    logic  cpu_pend;
    logic  tone_pend;
    hold_t cpu_e;
    hold_t tone_e;
    logic  cpu_ovr;
    logic  tone_ovr;
    logic  cpu_gnt;
    logic  tone_gnt;
    hold_t sel;
    logic  sel_ok;

    logic [1:0] cpu_wait_q;
    logic [1:0] cpu_wait_d;
    logic [7:0] ram_a_q;
    logic [7:0] ram_a_d;
    logic [7:0] ram_d_q;
    logic [7:0] ram_d_d;
    logic       ram_we_q;
    logic       ram_we_d;
    logic       ram_re_q;
    logic       ram_re_d;
    logic       cpu_rd_q;
    logic       cpu_rd_d;
    logic       tone_rd_q;
    logic       tone_rd_d;
    logic       rd_bad_q;
    logic       rd_bad_d;
    logic [7:0] cpu_q_q;
    logic [7:0] cpu_q_d;
    logic       cpu_q_en_q;
    logic       cpu_q_en_d;
    logic [7:0] tone_q_q;
    logic [7:0] tone_q_d;
    logic       tone_q_en_q;
    logic       tone_q_en_d;
    logic       overrun_q;
    logic       overrun_d;

    // Request formation; SCC mode folds channel E playback onto D at capture.
    always_comb begin
        cpu_cap       = cpu_ce & (cpu_we | cpu_oe);
        cpu_cap_e.id  = cpu_id;
        cpu_cap_e.a   = cpu_a;
        cpu_cap_e.d   = cpu_d;
        cpu_cap_e.op  = cpu_we ? OP_WRITE : OP_READ;
        tone_cap_e.id = (!scci_enable && tone_id == CH_E) ? CH_D : tone_id;
        tone_cap_e.a  = tone_a;
        tone_cap_e.d  = 8'h00;
        tone_cap_e.op = OP_READ;
    end

    scc_wave_req_slot u_cpu_slot (
        .clk       (clk),
        .nreset    (nreset),
        .cap       (cpu_cap),
        .cap_entry (cpu_cap_e),
        .grant     (cpu_gnt),
        .pend      (cpu_pend),
        .entry     (cpu_e),
        .ovr_hit   (cpu_ovr)
    );

    scc_wave_req_slot u_tone_slot (
        .clk       (clk),
        .nreset    (nreset),
        .cap       (tone_req),
        .cap_entry (tone_cap_e),
        .grant     (tone_gnt),
        .pend      (tone_pend),
        .entry     (tone_e),
        .ovr_hit   (tone_ovr)
    );

    // Tone-first arbitration with a bounded CPU wait counter.
    always_comb begin
        cpu_gnt  = cpu_pend &
                   (~tone_pend | (cpu_wait_q == CPU_MAX_WAIT));
        tone_gnt = tone_pend & ~cpu_gnt;
        sel      = cpu_gnt ? cpu_e : tone_e;
        sel_ok   = id_valid(sel.id);
        cpu_wait_d = cpu_wait_q;
        if (!cpu_pend || cpu_gnt) begin
            cpu_wait_d = 2'd0;
        end else if (tone_gnt) begin
            cpu_wait_d = cpu_wait_q + 2'd1;
        end
    end

    // RAM strobes for the granted entry and the two-stage read return.
    always_comb begin
        ram_we_d = (cpu_gnt | tone_gnt) & sel_ok & (sel.op == OP_WRITE);
        ram_re_d = (cpu_gnt | tone_gnt) & sel_ok & (sel.op == OP_READ);
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        if (ram_we_d || ram_re_d) begin
            ram_a_d = {sel.id, sel.a};
        end
        if (ram_we_d) begin
            ram_d_d = sel.d;
        end
        cpu_rd_d  = cpu_gnt & (cpu_e.op == OP_READ);
        tone_rd_d = tone_gnt & (tone_e.op == OP_READ);
        rd_bad_d  = ~sel_ok;

        cpu_q_en_d  = cpu_rd_q;
        cpu_q_d     = cpu_q_q;
        tone_q_en_d = tone_rd_q;
        tone_q_d    = tone_q_q;
        if (cpu_rd_q) begin
            cpu_q_d = rd_bad_q ? INVALID_READ_DATA : ram_q;
        end
        if (tone_rd_q) begin
            tone_q_d = rd_bad_q ? INVALID_READ_DATA : ram_q;
        end
        overrun_d = overrun_q | cpu_ovr | tone_ovr;
    end

    // Registered outputs and pipeline state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cpu_wait_q  <= 2'd0;
            ram_a_q     <= 8'h00;
            ram_d_q     <= 8'h00;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            cpu_rd_q    <= 1'b0;
            tone_rd_q   <= 1'b0;
            rd_bad_q    <= 1'b0;
            cpu_q_q     <= 8'h00;
            cpu_q_en_q  <= 1'b0;
            tone_q_q    <= 8'h00;
            tone_q_en_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cpu_wait_q  <= cpu_wait_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            cpu_rd_q    <= cpu_rd_d;
            tone_rd_q   <= tone_rd_d;
            rd_bad_q    <= rd_bad_d;
            cpu_q_q     <= cpu_q_d;
            cpu_q_en_q  <= cpu_q_en_d;
            tone_q_q    <= tone_q_d;
            tone_q_en_q <= tone_q_en_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_d     = ram_d_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign cpu_q     = cpu_q_q;
    assign cpu_q_en  = cpu_q_en_q;
    assign tone_q    = tone_q_q;
    assign tone_q_en = tone_q_en_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_scc_wave_ram_arbiter.sv
// Scoreboard bench for scc_wave_ram_arbiter with a behavioural wave RAM.
// Directed requests push expected strobes/returns; a monitor pops and compares.
module tb_scc_wave_ram_arbiter;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       scci_enable = 1'b1;
    logic       cpu_ce = 1'b0;
    logic [2:0] cpu_id = 3'd0;
    logic [4:0] cpu_a = 5'd0;
    logic [7:0] cpu_d = 8'h00;
    logic       cpu_oe = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_q;
    logic       cpu_q_en;
    logic       tone_req = 1'b0;
    logic [2:0] tone_id = 3'd0;
    logic [4:0] tone_a = 5'd0;
    logic [7:0] tone_q;
    logic       tone_q_en;
    logic [7:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic       ram_re;
    logic [7:0] ram_q;
    logic       overrun;

    always #5 clk = ~clk;

    scc_wave_ram_arbiter dut (
        .clk         (clk),
        .nreset      (nreset),
        .scci_enable (scci_enable),
        .cpu_ce      (cpu_ce),
        .cpu_id      (cpu_id),
        .cpu_a       (cpu_a),
        .cpu_d       (cpu_d),
        .cpu_oe      (cpu_oe),
        .cpu_we      (cpu_we),
        .cpu_q       (cpu_q),
        .cpu_q_en    (cpu_q_en),
        .tone_req    (tone_req),
        .tone_id     (tone_id),
        .tone_a      (tone_a),
        .tone_q      (tone_q),
        .tone_q_en   (tone_q_en),
        .ram_a       (ram_a),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_re      (ram_re),
        .ram_q       (ram_q),
        .overrun     (overrun)
    );

    // Wave RAM: preloaded with addr ^ 8'h5A, async read while ram_re.
    logic [7:0] mem [0:255];
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'(i) ^ 8'h5A;
            end
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
    end

    assign ram_q = ram_re ? mem[ram_a] : 8'h00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       we;
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } ram_exp_t;

    typedef struct {
        logic [7:0] d;
        int         c;
    } ret_exp_t;

    ram_exp_t ram_sb[$];
    ret_exp_t cpu_sb[$];
    ret_exp_t tone_sb[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic ok,
                       input string got, input string exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, got, exp);
        end
    endtask

    task automatic push_ram(input logic we, input logic [7:0] a,
                            input logic [7:0] d, input int c);
        ram_exp_t e;
        e.we = we; e.a = a; e.d = d; e.c = c;
        ram_sb.push_back(e);
    endtask

    task automatic push_ret(input logic is_cpu, input logic [7:0] d,
                            input int c);
        ret_exp_t e;
        e.d = d; e.c = c;
        if (is_cpu) cpu_sb.push_back(e);
        else tone_sb.push_back(e);
    endtask

    // Monitor: every strobe and every q_en must match the scoreboard head.
    ram_exp_t mr;
    ret_exp_t mc;
    ret_exp_t mt;

    always @(negedge clk) begin
        if (ram_we && ram_re) begin
            chk("ram_excl", 1'b0, "we and re", "single strobe");
        end
        if (ram_we || ram_re) begin
            if (ram_sb.size() == 0) begin
                chk("ram_unexpected", 1'b0,
                    $sformatf("we=%0b a=%0d cyc=%0d", ram_we, ram_a, cyc),
                    "no strobe");
            end else begin
                mr = ram_sb.pop_front();
                chk("ram_strobe",
                    ram_we == mr.we && ram_a == mr.a && cyc == mr.c &&
                    (!mr.we || ram_d == mr.d),
                    $sformatf("we=%0b a=%0d d=%02h cyc=%0d",
                              ram_we, ram_a, ram_d, cyc),
                    $sformatf("we=%0b a=%0d d=%02h cyc=%0d",
                              mr.we, mr.a, mr.d, mr.c));
            end
        end
        if (cpu_q_en) begin
            if (cpu_sb.size() == 0) begin
                chk("cpu_unexpected", 1'b0,
                    $sformatf("q=%02h cyc=%0d", cpu_q, cyc), "no return");
            end else begin
                mc = cpu_sb.pop_front();
                chk("cpu_return", cpu_q == mc.d && cyc == mc.c,
                    $sformatf("q=%02h cyc=%0d", cpu_q, cyc),
                    $sformatf("q=%02h cyc=%0d", mc.d, mc.c));
            end
        end
        if (tone_q_en) begin
            if (tone_sb.size() == 0) begin
                chk("tone_unexpected", 1'b0,
                    $sformatf("q=%02h cyc=%0d", tone_q, cyc), "no return");
            end else begin
                mt = tone_sb.pop_front();
                chk("tone_return", tone_q == mt.d && cyc == mt.c,
                    $sformatf("q=%02h cyc=%0d", tone_q, cyc),
                    $sformatf("q=%02h cyc=%0d", mt.d, mt.c));
            end
        end
    end

    task automatic cpu_issue(input logic [2:0] id, input logic [4:0] a,
                             input logic [7:0] d, input logic we,
                             input logic oe);
        cpu_ce = 1'b1; cpu_id = id; cpu_a = a; cpu_d = d;
        cpu_we = we; cpu_oe = oe;
    endtask

    task automatic tone_issue(input logic [2:0] id, input logic [4:0] a);
        tone_req = 1'b1; tone_id = id; tone_a = a;
    endtask

    task automatic tick();
        @(negedge clk);
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0; tone_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name,
            {ram_a, ram_d, cpu_q, tone_q,
             ram_we, ram_re, cpu_q_en, tone_q_en, overrun} == 37'd0,
            $sformatf("a=%0d d=%02h cq=%02h tq=%02h we=%0b re=%0b ce=%0b te=%0b ov=%0b",
                      ram_a, ram_d, cpu_q, tone_q, ram_we, ram_re,
                      cpu_q_en, tone_q_en, overrun),
            "all zero");
    endtask

    int t;

    initial begin
        idle(2);
        chk_reset_outs("reset_state");
        #2 nreset = 1'b1;
        idle(2);

        // Write 3C to ch2[5] (addr 69), then read it back.
        t = cyc;
        cpu_issue(3'd2, 5'd5, 8'h3C, 1'b1, 1'b0);
        push_ram(1'b1, 8'd69, 8'h3C, t + 2);
        tick();
        idle(4);
        t = cyc;
        cpu_issue(3'd2, 5'd5, 8'h00, 1'b0, 1'b1);
        push_ram(1'b0, 8'd69, 8'h00, t + 2);
        push_ret(1'b1, 8'h3C, t + 3);
        tick();
        idle(4);

        // Write wins over read when both qualifiers are high.
        t = cyc;
        cpu_issue(3'd0, 5'd9, 8'hA5, 1'b1, 1'b1);
        push_ram(1'b1, 8'd9, 8'hA5, t + 2);
        tick();
        idle(4);
        t = cyc;
        cpu_issue(3'd0, 5'd9, 8'h00, 1'b0, 1'b1);
        push_ram(1'b0, 8'd9, 8'h00, t + 2);
        push_ret(1'b1, 8'hA5, t + 3);
        tick();
        idle(4);

        // Neither qualifier: request discarded.
        cpu_issue(3'd1, 5'd1, 8'hEE, 1'b0, 1'b0);
        tick();
        idle(4);

        // SCC mode: channel E playback reads channel D (addr 103).
        scci_enable = 1'b0;
        t = cyc;
        tone_issue(3'd4, 5'd7);
        push_ram(1'b0, 8'd103, 8'h00, t + 2);
        push_ret(1'b0, 8'h3D, t + 3);
        tick();
        idle(4);

        // SCC-I mode: channel E is its own bank (addr 135).
        scci_enable = 1'b1;
        t = cyc;
        tone_issue(3'd4, 5'd7);
        push_ram(1'b0, 8'd135, 8'h00, t + 2);
        push_ret(1'b0, 8'hDD, t + 3);
        tick();
        idle(4);

        // Invalid id: read returns FF with no strobe, write is dropped.
        t = cyc;
        cpu_issue(3'd6, 5'd0, 8'h00, 1'b0, 1'b1);
        push_ret(1'b1, 8'hFF, t + 3);
        tick();
        idle(4);
        cpu_issue(3'd7, 5'd3, 8'h11, 1'b1, 1'b0);
        tick();
        idle(4);

        chk("overrun_clear", overrun == 1'b0,
            $sformatf("%0b", overrun), "0");

        // Continuous tone with a CPU read: T,T,CPU; tone2 is overwritten.
        t = cyc;
        push_ram(1'b0, 8'd0, 8'h00, t + 2);
        push_ram(1'b0, 8'd1, 8'h00, t + 3);
        push_ram(1'b0, 8'd34, 8'h00, t + 4);
        push_ram(1'b0, 8'd3, 8'h00, t + 5);
        push_ram(1'b0, 8'd4, 8'h00, t + 6);
        push_ram(1'b0, 8'd5, 8'h00, t + 7);
        push_ret(1'b0, 8'h5A, t + 3);
        push_ret(1'b0, 8'h5B, t + 4);
        push_ret(1'b1, 8'h78, t + 5);
        push_ret(1'b0, 8'h59, t + 6);
        push_ret(1'b0, 8'h5E, t + 7);
        push_ret(1'b0, 8'h5F, t + 8);
        for (int k = 0; k < 6; k++) begin
            tone_issue(3'd0, 5'(k));
            if (k == 0) cpu_issue(3'd1, 5'd2, 8'h00, 1'b0, 1'b1);
            tick();
        end
        idle(6);
        chk("overrun_set", overrun == 1'b1,
            $sformatf("%0b", overrun), "1");

        // Reset right after a grant: the return must never appear.
        t = cyc;
        cpu_issue(3'd1, 5'd1, 8'h00, 1'b0, 1'b1);
        push_ram(1'b0, 8'd33, 8'h00, t + 2);
        tick();
        @(negedge clk);
        #2 nreset = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset_mid_op");
        #2 nreset = 1'b1;
        idle(6);
        chk_reset_outs("after_reset_idle");

        chk("ram_sb_drained", ram_sb.size() == 0,
            $sformatf("%0d left", ram_sb.size()), "0 left");
        chk("cpu_sb_drained", cpu_sb.size() == 0,
            $sformatf("%0d left", cpu_sb.size()), "0 left");
        chk("tone_sb_drained", tone_sb.size() == 0,
            $sformatf("%0d left", tone_sb.size()), "0 left");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/scc_wave_ram_arbiter.md
# scc_wave_ram_arbiter

Arbitrates the single-port 160-byte SCC/SCC-I wave RAM (5 channels × 32 bytes) between two requesters: the CPU-side register block's wave port and the tone generator's playback fetch port. Each port has a one-entry holding register. Tone has priority, with a bounded-wait rule for the CPU. In SCC-compatible mode the block remaps channel E playback onto channel D's waveform. Read data is returned per port with a one-cycle valid strobe.

## Interface
- No parameters.
- clk  in  1  system clock
- nreset  in  1  reset, asynchronous, active-low
- scci_enable  in  1  1 = SCC-I mode; 0 = SCC mode (tone channel E plays channel D)
- cpu_ce  in  1  one-cycle CPU access request
- cpu_id  in  3  channel 0..4 (A..E)
- cpu_a  in  5  byte index within channel
- cpu_d  in  8  write data
- cpu_oe  in  1  read request qualifier
- cpu_we  in  1  write request qualifier
- cpu_q  out  8  CPU read data
- cpu_q_en  out  1  one-cycle valid for cpu_q
- tone_req  in  1  one-cycle playback fetch request
- tone_id  in  3  channel 0..4
- tone_a  in  5  sample index
- tone_q  out  8  fetched sample
- tone_q_en  out  1  one-cycle valid for tone_q
- ram_a  out  8  RAM address, {id, a}, range 0..159
- ram_d  out  8  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_q  in  8  RAM read data, valid the cycle after ram_re
- overrun  out  1  sticky; set when a pending request is overwritten

## Operation
- Capture
  - cpu_ce=1 loads the CPU hold register {id, a, d, op} and sets cpu_pend.
  - op = write if cpu_we=1, else read if cpu_oe=1, else the request is discarded.
  - Write wins when oe and we are both high; that access produces no read return.
  - tone_req=1 loads the tone hold register. The tone id is remapped 4→3 when scci_enable=0, sampled at capture.
- Overrun: a new request on a port whose pend is still set overwrites the old entry and sets overrun. overrun clears only on reset.
- Arbitration, evaluated each cycle over the pend flags:
  - Only one pending: it is granted.
  - Both pending and cpu_wait < 2: tone is granted and cpu_wait increments.
  - Both pending and cpu_wait == 2: CPU is granted.
  - cpu_wait clears on every CPU grant and whenever cpu_pend=0.
- Grant actions: drive ram_a/ram_d/ram_we/ram_re for one cycle and clear the granted port's pend.
- Invalid id (5..7): no RAM strobe is issued. A read still returns 8'hFF with its q_en at the normal latency; a write is silently dropped.
- Same-cycle capture and grant on one port: capture lands in the hold register after the grant consumes the old entry. This is not an overrun.
- States per port: IDLE (pend=0), PEND, GRANT, DATA (return in flight). A port may be PEND while its previous read is still in DATA.

## Timing
- Capture at edge E0 (request sampled high) sets pend.
- Earliest grant: RAM strobes registered at E1.
- ram_q is valid during the cycle after E1 and is registered into cpu_q/tone_q with q_en at E2.
- Minimum request-to-data latency is 2 clocks.
- Worst-case CPU latency under continuous tone traffic is 4 clocks.
- Write to a later read of the same address returns the new data.
- Reset values:
  - ram_a, ram_d, cpu_q, tone_q = 0.
  - ram_we, ram_re, cpu_q_en, tone_q_en, overrun = 0.
  - pend flags and cpu_wait = 0.
- Reset mid-operation clears pending entries and suppresses in-flight returns; no q_en is produced after nreset deasserts.
- All outputs are registered.
- At most one RAM strobe per cycle; ram_we and ram_re are never high together.

## Structure
- Shared package scc_pkg holds:
  - channel id constants (CH_A=0..CH_E=4)
  - WAVE_DEPTH=32, RAM_DEPTH=160
  - CPU_MAX_WAIT=2
  - INVALID_READ_DATA=8'hFF
  - hold-register struct {id, a, d, op}
- One natural sub-module, scc_wave_req_slot: the per-port hold register with capture, pend and overrun logic. It is instantiated twice, CPU and tone.
- Arbitration, address formation and the return pipeline stay in the top module.

## Test plan
- CPU write id=2, a=5, d=8'h3C, no tone traffic:
  - ram_a=8'd69 and ram_we at E1.
  - A CPU read of the same address returns cpu_q=8'h3C with cpu_q_en at E2 of that read.
- tone_req every cycle, and CPU read issued at cycle 0:
  - Tone is granted for two cycles, then CPU.
  - cpu_q_en occurs exactly 4 clocks after cpu_ce.
- scci_enable=0, tone_id=4, a=7: ram_a=8'd103.
- scci_enable=1, tone_id=4, a=7: ram_a=8'd135.
- CPU read with id=6: no ram_re; cpu_q=8'hFF, cpu_q_en at +2.
- Two tone_req while tone is blocked by a forced CPU grant: overrun=1; only the second request's data returns.
- nreset asserted in the cycle after a grant: no q_en is produced, and every output holds its reset value.
